// File: rtl/eva_rank_engine.sv
// Epoch controller and EVA ranking engine: snapshots hit histograms each epoch,
// then runs a SUM pass and a SCAN pass to publish per-age EVA scores and a victim age.
module eva_rank_engine #(
    parameter int k              = 3,
    parameter int ctrLen         = 10,
    parameter int accessCtrWidth = 13
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              access,
    input  logic [ctrLen*(2**k)-1:0]          hitCtr_R_1D,
    input  logic [ctrLen*(2**k)-1:0]          hitCtr_NR_1D,
    output logic                              update_EVA,
    output logic                              busy,
    output logic                              eva_done,
    output logic                              eva_valid,
    output logic                              overrun,
    output logic [k-1:0]                      victim_age,
    output logic [(ctrLen+k+1)*(2**k)-1:0]    eva_R_1D,
    output logic [(ctrLen+k+1)*(2**k)-1:0]    eva_NR_1D
);
    localparam int N  = 2**k;
    localparam int W  = ctrLen + k + 1;
    localparam int TW = ctrLen + k;

    typedef enum logic [2:0] {IDLE, CAPTURE, SUM, SCAN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [accessCtrWidth-1:0]    epoch_q, epoch_d;
    logic                         ovr_q, ovr_d;
    logic [k-1:0]                 idx_q, idx_d;
    logic [ctrLen*N-1:0]          snapR_q, snapR_d, snapNR_q, snapNR_d;
    logic [TW-1:0]                totR_q, totR_d, totNR_q, totNR_d;
    logic [TW-1:0]                costR_q, costR_d, costNR_q, costNR_d;
    logic [TW-1:0]                cumR_q, cumR_d, cumNR_q, cumNR_d;
    logic [TW-1:0]                accR_q, accR_d, accNR_q, accNR_d;
    logic [W*N-1:0]               shR_q, shR_d, shNR_q, shNR_d;
    logic signed [W-1:0]          min_q, min_d;
    logic [k-1:0]                 vict_q, vict_d;
    logic [W*N-1:0]               evaR_q, evaR_d, evaNR_q, evaNR_d;
    logic [k-1:0]                 vage_q, vage_d;
    logic                         valid_q, valid_d;

    logic                         trig;
    logic [ctrLen-1:0]            selR, selNR;
    logic [TW-1:0]                sumR, sumNR;
    logic [TW-1:0]                ncumR, ncumNR, naccR, naccNR;
    logic signed [W-1:0]          diffR, diffNR;

    assign trig   = access && (&epoch_q);
    assign selR   = snapR_q[idx_q*ctrLen +: ctrLen];
    assign selNR  = snapNR_q[idx_q*ctrLen +: ctrLen];
    assign sumR   = totR_q + TW'(selR);
    assign sumNR  = totNR_q + TW'(selNR);
    assign ncumR  = cumR_q + TW'(selR);
    assign ncumNR = cumNR_q + TW'(selNR);
    assign naccR  = accR_q + costR_q;
    assign naccNR = accNR_q + costNR_q;
    // Operands are bounded by N*(2**ctrLen-1), so the W-bit difference never wraps.
    assign diffR  = $signed({1'b0, ncumR}) - $signed({1'b0, naccR});
    assign diffNR = $signed({1'b0, ncumNR}) - $signed({1'b0, naccNR});

    always_comb begin
        state_d  = state_q;
        epoch_d  = access ? epoch_q + 1'b1 : epoch_q;
        ovr_d    = ovr_q;
        idx_d    = idx_q;
        snapR_d  = snapR_q;
        snapNR_d = snapNR_q;
        totR_d   = totR_q;
        totNR_d  = totNR_q;
        costR_d  = costR_q;
        costNR_d = costNR_q;
        cumR_d   = cumR_q;
        cumNR_d  = cumNR_q;
        accR_d   = accR_q;
        accNR_d  = accNR_q;
        shR_d    = shR_q;
        shNR_d   = shNR_q;
        min_d    = min_q;
        vict_d   = vict_q;
        evaR_d   = evaR_q;
        evaNR_d  = evaNR_q;
        vage_d   = vage_q;
        valid_d  = valid_q;

        if (trig && state_q != IDLE) ovr_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = CAPTURE;
                    totR_d  = '0;
                    totNR_d = '0;
                    cumR_d  = '0;
                    cumNR_d = '0;
                    accR_d  = '0;
                    accNR_d = '0;
                end
            end
            CAPTURE: begin
                snapR_d  = hitCtr_R_1D;
                snapNR_d = hitCtr_NR_1D;
                idx_d    = '0;
                state_d  = SUM;
            end
            SUM: begin
                totR_d  = sumR;
                totNR_d = sumNR;
                idx_d   = idx_q + 1'b1;
                if (&idx_q) begin
                    costR_d  = sumR >> k;
                    costNR_d = sumNR >> k;
                    idx_d    = '1;
                    min_d    = {1'b0, {(W-1){1'b1}}};
                    vict_d   = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                cumR_d  = ncumR;
                cumNR_d = ncumNR;
                accR_d  = naccR;
                accNR_d = naccNR;
                shR_d[idx_q*W +: W]  = diffR;
                shNR_d[idx_q*W +: W] = diffNR;
                if (diffNR < min_q) begin
                    min_d  = diffNR;
                    vict_d = idx_q;
                end
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    evaR_d  = shR_d;
                    evaNR_d = shNR_d;
                    vage_d  = vict_d;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            epoch_q  <= '0;
            ovr_q    <= 1'b0;
            idx_q    <= '0;
            snapR_q  <= '0;
            snapNR_q <= '0;
            totR_q   <= '0;
            totNR_q  <= '0;
            costR_q  <= '0;
            costNR_q <= '0;
            cumR_q   <= '0;
            cumNR_q  <= '0;
            accR_q   <= '0;
            accNR_q  <= '0;
            shR_q    <= '0;
            shNR_q   <= '0;
            min_q    <= '0;
            vict_q   <= '0;
            evaR_q   <= '0;
            evaNR_q  <= '0;
            vage_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            epoch_q  <= epoch_d;
            ovr_q    <= ovr_d;
            idx_q    <= idx_d;
            snapR_q  <= snapR_d;
            snapNR_q <= snapNR_d;
            totR_q   <= totR_d;
            totNR_q  <= totNR_d;
            costR_q  <= costR_d;
            costNR_q <= costNR_d;
            cumR_q   <= cumR_d;
            cumNR_q  <= cumNR_d;
            accR_q   <= accR_d;
            accNR_q  <= accNR_d;
            shR_q    <= shR_d;
            shNR_q   <= shNR_d;
            min_q    <= min_d;
            vict_q   <= vict_d;
            evaR_q   <= evaR_d;
            evaNR_q  <= evaNR_d;
            vage_q   <= vage_d;
            valid_q  <= valid_d;
        end
    end

    assign update_EVA = (state_q == CAPTURE);
    assign busy       = (state_q != IDLE);
    assign eva_done   = (state_q == DONE);
    assign eva_valid  = valid_q;
    assign overrun    = ovr_q;
    assign victim_age = vage_q;
    assign eva_R_1D   = evaR_q;
    assign eva_NR_1D  = evaNR_q;

endmodule

// File: tb/tb_eva_rank_engine.sv
// Directed bench for eva_rank_engine with a short epoch (16 accesses);
// expected scores come from a closed-form suffix-sum model held in a queue.
module tb_eva_rank_engine;
    localparam int K   = 3;
    localparam int N   = 8;
    localparam int CL  = 10;
    localparam int W   = 14;
    localparam int ACW = 4;

    typedef struct {
        logic [W*N-1:0] r;
        logic [W*N-1:0] nr;
        logic [K-1:0]   v;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              access;
    logic [CL*N-1:0]   hitCtr_R_1D, hitCtr_NR_1D;
    logic              update_EVA, busy, eva_done, eva_valid, overrun;
    logic [K-1:0]      victim_age;
    logic [W*N-1:0]    eva_R_1D, eva_NR_1D;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   hR[N];
    int   hNR[N];
    exp_t q[$];

    eva_rank_engine #(.k(K), .ctrLen(CL), .accessCtrWidth(ACW)) dut (
        .clk          (clk),
        .rst          (rst),
        .access       (access),
        .hitCtr_R_1D  (hitCtr_R_1D),
        .hitCtr_NR_1D (hitCtr_NR_1D),
        .update_EVA   (update_EVA),
        .busy         (busy),
        .eva_done     (eva_done),
        .eva_valid    (eva_valid),
        .overrun      (overrun),
        .victim_age   (victim_age),
        .eva_R_1D     (eva_R_1D),
        .eva_NR_1D    (eva_NR_1D)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // EVA[a] = sum_{j>=a} h[j] - (tot>>3)*(N-a); victim = first strict minimum from age 7 down.
    function automatic exp_t model();
        exp_t e;
        int tr = 0, tn = 0, sr = 0, sn = 0, cr, cn, er, en;
        int mn = 8191;
        for (int a = 0; a < N; a++) begin
            tr += hR[a];
            tn += hNR[a];
        end
        cr = tr >> 3;
        cn = tn >> 3;
        e.r = '0;
        e.nr = '0;
        e.v = '0;
        for (int a = N - 1; a >= 0; a--) begin
            sr += hR[a];
            sn += hNR[a];
            er = sr - cr * (N - a);
            en = sn - cn * (N - a);
            e.r[a*W +: W]  = W'(er);
            e.nr[a*W +: W] = W'(en);
            if (en < mn) begin
                mn = en;
                e.v = K'(a);
            end
        end
        return e;
    endfunction

    task automatic drive_hist();
        for (int a = 0; a < N; a++) begin
            hitCtr_R_1D[a*CL +: CL]  = CL'(hR[a]);
            hitCtr_NR_1D[a*CL +: CL] = CL'(hNR[a]);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_evaR"}, 128'(eva_R_1D), 128'(0));
        chk({tag, "_evaNR"}, 128'(eva_NR_1D), 128'(0));
        chk({tag, "_victim"}, 128'(victim_age), 128'(0));
        chk({tag, "_valid"}, 128'(eva_valid), 128'(0));
        chk({tag, "_overrun"}, 128'(overrun), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(eva_done), 128'(0));
        chk({tag, "_upd"}, 128'(update_EVA), 128'(0));
    endtask

    // mode 0: plain epoch, 1: extra trigger forced during SCAN, 2: reset in 3rd SCAN cycle
    task automatic run_epoch(input string tag, input int mode);
        exp_t e;
        exp_t last;
        int   done_c = 0;
        int   nupd = 0;
        int   nbusy = 0;
        int   npulse = 0;
        drive_hist();
        if (mode != 2) q.push_back(model());
        access = 1'b1;
        repeat (16) tick();
        if (mode != 1) access = 1'b0;
        chk({tag, "_upd_T1"}, 128'(update_EVA), 128'(1));
        for (int c = 1; c <= 24; c++) begin
            if (c > 1) tick();
            if (c == 2) begin
                hitCtr_R_1D  = '0;
                hitCtr_NR_1D = '0;
            end
            if (mode == 1 && c == 17) access = 1'b0;
            if (mode == 2 && c == 12) begin
                rst = 1'b1;
                #1;
                chk_zero({tag, "_rst"});
                tick();
                tick();
                rst = 1'b0;
                for (int j = 0; j < 20; j++) begin
                    tick();
                    if (eva_done) npulse++;
                end
                chk({tag, "_no_done"}, 128'(npulse), 128'(0));
                chk({tag, "_valid_after"}, 128'(eva_valid), 128'(0));
                break;
            end
            if (update_EVA) nupd++;
            if (busy) nbusy++;
            if (eva_done) begin
                if (done_c == 0) done_c = c;
                if (q.size() == 0) begin
                    chk({tag, "_queue_empty"}, 128'(1), 128'(0));
                end else begin
                    e = q.pop_front();
                    last = e;
                    chk({tag, "_evaR"}, 128'(eva_R_1D), 128'(e.r));
                    chk({tag, "_evaNR"}, 128'(eva_NR_1D), 128'(e.nr));
                    chk({tag, "_victim"}, 128'(victim_age), 128'(e.v));
                    chk({tag, "_valid"}, 128'(eva_valid), 128'(1));
                end
            end
        end
        if (mode != 2) begin
            chk({tag, "_done_cycle"}, 128'(done_c), 128'(18));
            chk({tag, "_upd_count"}, 128'(nupd), 128'(1));
            chk({tag, "_busy_count"}, 128'(nbusy), 128'(18));
            if (done_c != 0) begin
                chk({tag, "_hold_evaR"}, 128'(eva_R_1D), 128'(last.r));
                chk({tag, "_hold_evaNR"}, 128'(eva_NR_1D), 128'(last.nr));
            end
            chk({tag, "_overrun"}, 128'(overrun), 128'(mode == 1));
        end
    endtask

    initial begin
        rst = 1'b1;
        access = 1'b0;
        hitCtr_R_1D = '0;
        hitCtr_NR_1D = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        for (int a = 0; a < N; a++) begin hR[a] = 0; hNR[a] = 0; end
        hR[0] = 8;
        run_epoch("r_age0", 0);

        for (int a = 0; a < N; a++) begin hR[a] = 0; hNR[a] = 0; end
        hNR[7] = 16;
        run_epoch("nr_age7", 0);

        for (int a = 0; a < N; a++) begin hR[a] = a * 10 + 5; hNR[a] = 4; end
        run_epoch("uniform", 0);

        for (int a = 0; a < N; a++) begin hR[a] = 1023; hNR[a] = 1023; end
        run_epoch("saturate", 1);

        for (int a = 0; a < N; a++) begin
            hR[a] = $urandom_range(0, 1023);
            hNR[a] = $urandom_range(0, 1023);
        end
        run_epoch("rst_scan", 2);

        for (int a = 0; a < N; a++) begin
            hR[a] = $urandom_range(0, 1023);
            hNR[a] = $urandom_range(0, 1023);
        end
        run_epoch("after_rst", 0);

        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/eva_rank_engine.md
# eva_rank_engine

Epoch controller and EVA ranking engine for the EVA replacement path. It counts cache accesses and, at each epoch boundary, pulses `update_EVA` so the hit-counter block clears. In the same clock it snapshots the per-age reused and non-reused hit histograms. It then runs a two-pass sequential scan that produces per-age EVA scores for both classes and a preferred non-reused victim age, which the replacement logic consumes.

## Interface
- `k`, 3: age width; `N = 2**k` age buckets (derived, not overridable).
- `ctrLen`, 10: width of each hit-histogram entry.
- `accessCtrWidth`, 13: epoch length is `2**accessCtrWidth` accesses.
- Derived widths: `W = ctrLen+k+1` (signed EVA score); total/cumulative registers are `ctrLen+k` bits.

Ports (clock and reset first):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `access`  in  1  one pulse per cache access (hit or miss).
- `hitCtr_R_1D`  in  ctrLen*N  reused-class histogram; entry a at `[a*ctrLen +: ctrLen]`.
- `hitCtr_NR_1D`  in  ctrLen*N  non-reused-class histogram, same packing.
- `update_EVA`  out  1  one-cycle epoch pulse; the hit-counter block clears on this edge.
- `busy`  out  1  high from CAPTURE through DONE.
- `eva_done`  out  1  one-cycle pulse when new results are published.
- `eva_valid`  out  1  sticky; high once the first results are published.
- `overrun`  out  1  sticky; set when an epoch boundary arrives while busy.
- `victim_age`  out  k  age with minimum non-reused EVA.
- `eva_R_1D`, `eva_NR_1D`  out  W*N  signed per-age scores; entry a at `[a*W +: W]`.

## Operation
- Reset values: all outputs 0, state IDLE, epoch counter 0, all snapshot, shadow and accumulator registers 0.
- Epoch counter: increments on every `access`, in every state, and wraps from all-ones to 0.
- Trigger: `access` while the counter is all-ones.
  - If state is IDLE, go to CAPTURE.
  - Otherwise the trigger is dropped and `overrun` is set.
- States:
  - IDLE: waits for a trigger.
  - CAPTURE: `update_EVA` is 1. At the exit edge, both histograms are latched into snapshot registers. These are pre-clear values because the clear happens on the same edge.
  - SUM: N cycles, idx = 0..N-1. Computes `tot_c += snap_c[idx]` for c in {R, NR}. On exit, `cost_c = tot_c >> k`.
  - SCAN: N cycles, a = N-1 down to 0. Each cycle:
    - `cum_c += snap_c[a]`
    - `costAcc_c += cost_c`, so `costAcc_c = cost_c*(N-a)` with no multiplier
    - `shadow_c[a] = cum_c - costAcc_c`, signed, W bits
  - Victim tracking during SCAN: the victim register is replaced only when `eva_NR[a] < min` (strict compare; min initialised to the most positive W-bit value). Ties therefore keep the larger age.
  - DONE: one cycle with `eva_done` = 1, then IDLE.
- Publishing: at the edge ending the last SCAN cycle, the `eva_*_1D` outputs, `victim_age` and `eva_valid` update atomically. Outputs stay stable at all other times.
- `tot`, `cum` and `costAcc` are cleared on CAPTURE entry.
- Widths: `tot`, `cum` and `costAcc` are never greater than `N*(2**ctrLen-1)` and never overflow `ctrLen+k` bits. The difference always fits W signed bits, so no saturation logic is needed.

## Timing
- Trigger accepted in cycle T:
  - `update_EVA` and `busy` high in T+1.
  - SUM in T+2..T+N+1.
  - SCAN in T+N+2..T+2N+1.
  - New outputs visible and `eva_done` high in T+2N+2.
  - IDLE in T+2N+3; `busy` low from T+2N+3.
  - With N=8, results appear 18 cycles after the trigger.
- Earliest next trigger is `2**accessCtrWidth` accesses later. Triggers during T+1..T+2N+2 set `overrun`.
- `rst` at any point (mid-SUM, mid-SCAN) clears immediately and asynchronously:
  - Clears all state and outputs, including `eva_valid` and `overrun`.
  - No partial results are published.
  - The epoch restarts from 0.
- An `access` in the same cycle `rst` deasserts is not counted unless `rst` is already low at that edge.

## Test plan
- Epoch timing (`accessCtrWidth`=4): 16 `access` pulses → exactly one `update_EVA` pulse in the cycle after the 16th; `eva_done` 18 cycles after the 16th; `busy` high 18 cycles.
- Single-bucket R histogram, age0 = 8, others 0:
  - cost_R = 1; eva_R[7..1] = -1..-7 and eva_R[0] = 0.
  - Snapshot unaffected by the histogram being cleared after CAPTURE.
- NR histogram with age7 = 16, others 0: eva_NR[7..0] = 14, 12, 10, 8, 6, 4, 2, 0; `victim_age` = 0.
- Uniform NR of 4 per age: all eva_NR = 0; tie → `victim_age` = 7.
- Saturation: all entries 1023 → tot = 8184, cost = 1023, every score 0, no overflow. `overrun` set by an extra trigger forced during SCAN; outputs unaffected.
- Reset mid-SCAN: `rst` high in the 3rd SCAN cycle:
  - All outputs 0 immediately, `eva_done` never pulses, `eva_valid` = 0.
  - The next full epoch produces correct results.
